ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the decoded op type and the two register operands latched by ID/EX. It computes MULT/MULTU/DIV/DIVU into HI/LO over multiple cycles and also executes MTHI/MTLO writes. While an operation is in flight it raises a stall request to hold IF/ID/EX.

Parameters:
WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  begin operation in op using operand_a/operand_b; sampled only in IDLE
op  input  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU
operand_a  input  WIDTH  rs value (multiplicand / dividend)
operand_b  input  WIDTH  rt value (multiplier / divisor)
flush  input  1  abort in-flight operation (branch/exception squash)
hi_lo_access  input  1  current EX instruction reads or writes HI/LO (MFHI/MFLO/MTHI/MTLO)
hi_we  input  1  MTHI write enable
lo_we  input  1  MTLO write enable
wdata  input  WIDTH  MTHI/MTLO data
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse when hi/lo receive a new mul/div result
stall_req  output  1  combinational: busy & (start | hi_lo_access)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; hi=0; lo=0; done=0; internal counters, shift registers and sign flags = 0. Reset mid-operation discards the operation immediately.
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - start=1 at edge E0: capture |a| and |b| (absolute values for signed ops, raw values for unsigned ops). Record result signs: quotient/product sign = sign_a^sign_b; remainder sign = sign_a. Set count=0 and go to CALC.
  - Else if hi_we or lo_we: write wdata into the selected register(s) at that edge.
  - start has priority over hi_we/lo_we in the same cycle; the writes are dropped.
- CALC: one radix-2 step per edge, count increments.
  - Multiply: shift-add producing a 2*WIDTH-bit product.
  - Divide: restoring division producing quotient and remainder.
  - At the edge where count reaches WIDTH-1 (E32 for WIDTH=32), go to FIX.
- FIX (edge E33):
  - Apply two's-complement sign correction.
  - Multiply: hi = product[2W-1:W], lo = product[W-1:0].
  - Divide: lo = quotient, hi = remainder.
  - done=1 during the cycle following E33; return to IDLE.
  - Total latency: start sampled at E0, result visible after E33 (33 cycles); busy high for 33 cycles.
- Divide by zero: no trap; the natural restoring result is used, i.e. magnitude quotient = all ones, remainder = |dividend|, followed by normal sign fix.
  - DIVU x/0: lo=0xFFFFFFFF, hi=x.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- flush=1 in CALC or FIX: next state IDLE, hi/lo unchanged, done stays 0. flush in IDLE has no effect on state; MTHI/MTLO writes in that cycle are suppressed.
- start while busy: ignored (stall_req holds the pipeline so the instruction re-presents itself).
- hi_we/lo_we while busy: ignored (stall_req covers it).
- Reads of hi/lo during busy return the old values; the consumer must honour stall_req.

Decomposition:
- Package muldiv_pkg:
  - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU)
  - FSM state enum (IDLE/CALC/FIX)
  - localparam for count width, clog2(WIDTH)
- One sub-module, muldiv_datapath: holds the shift/accumulate registers, the WIDTH+1-bit adder/subtractor and the sign fix. The control FSM, HI/LO registers and stall logic stay in ex_muldiv_unit.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done pulse 33 cycles after start; hi=0xFFFFFFFE, lo=0x00000001; busy high exactly 33 cycles.
- MULT 0xFFFFFFFD (-3) x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 0x64 / 0 -> lo=0xFFFFFFFF, hi=0x00000064. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Preload hi=0x11, lo=0x22 via hi_we/lo_we. Start MULT, assert flush 10 cycles later -> busy=0 next cycle, done never pulses, hi=0x11, lo=0x22.
- During busy, assert hi_lo_access=1 -> stall_req=1 in the same cycle. With busy=0, hi_lo_access=1 and hi_we=1 with wdata=0xABCD -> stall_req=0, hi=0xABCD after the edge.
- Assert reset=0 asynchronously (between edges) mid-CALC -> hi=lo=0, busy=0, done=0 immediately. After release, a new MULTU 3x4 gives lo=12, hi=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage iterative multiply/divide unit:
// op encodings, control FSM states and iteration counter width.
package muldiv_pkg;

    localparam int MD_WIDTH = 32;
    localparam int CNT_W    = $clog2(MD_WIDTH);

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// Magnitude shift-add multiplier / restoring divider sharing one 2*WIDTH
// accumulator, plus the final two's-complement sign correction.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    // Multiply: acc = {partial product, multiplier}. Divide: acc = {remainder, quotient}.
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   opnd_r;
    logic               is_div_r;
    logic               neg_q_r;
    logic               neg_rem_r;

    logic               is_div_s;
    logic               sign_a_s;
    logic               sign_b_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_part_s;
    logic [WIDTH+1:0]   div_diff_s;
    logic [2*WIDTH-1:0] acc_next_s;
    logic [2*WIDTH-1:0] prod_neg_s;

    // Operand decode: magnitudes and sign flags for the op being started
    always_comb begin
        is_div_s = (op == OP_DIV) || (op == OP_DIVU);
        sign_a_s = ((op == OP_MULT) || (op == OP_DIV)) && operand_a[WIDTH-1];
        sign_b_s = ((op == OP_MULT) || (op == OP_DIV)) && operand_b[WIDTH-1];
        a_mag_s  = sign_a_s ? (~operand_a + WIDTH'(1)) : operand_a;
        b_mag_s  = sign_b_s ? (~operand_b + WIDTH'(1)) : operand_b;
    end

    // One radix-2 iteration; a borrow out of the subtract means "restore"
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
        div_part_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        div_diff_s = {1'b0, div_part_s} - {2'b00, opnd_r};
        if (is_div_r) begin
            if (div_diff_s[WIDTH+1]) begin
                acc_next_s = {div_part_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
            end else begin
                acc_next_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
            end
        end else if (acc_r[0]) begin
            acc_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        end else begin
            acc_next_s = {1'b0, acc_r[2*WIDTH-1:1]};
        end
    end

    // Accumulator, operand and sign-flag registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_r     <= '0;
            opnd_r    <= '0;
            is_div_r  <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
        end else if (load) begin
            acc_r     <= {{WIDTH{1'b0}}, (is_div_s ? a_mag_s : b_mag_s)};
            opnd_r    <= is_div_s ? b_mag_s : a_mag_s;
            is_div_r  <= is_div_s;
            neg_q_r   <= sign_a_s ^ sign_b_s;
            neg_rem_r <= sign_a_s;
        end else if (step) begin
            acc_r <= acc_next_s;
        end else begin
            acc_r <= acc_r;
        end
    end

    // Sign correction of the finished magnitudes
    always_comb begin
        prod_neg_s = ~acc_r + (2*WIDTH)'(1);
        if (is_div_r) begin
            res_lo = neg_q_r ? (~acc_r[WIDTH-1:0] + WIDTH'(1)) : acc_r[WIDTH-1:0];
            res_hi = neg_rem_r ? (~acc_r[2*WIDTH-1:WIDTH] + WIDTH'(1))
                               : acc_r[2*WIDTH-1:WIDTH];
        end else if (neg_q_r) begin
            {res_hi, res_lo} = prod_neg_s;
        end else begin
            {res_hi, res_lo} = acc_r;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit: control FSM, HI/LO architectural registers,
// MTHI/MTLO writes and the pipeline stall request.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    input  logic             hi_lo_access,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall_req
);

    state_e             state_r;
    state_e             next_state_s;
    logic [CNT_W-1:0]   count_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               done_r;
    logic               accept_s;
    logic               mt_we_s;
    logic               commit_s;
    logic [WIDTH-1:0]   res_hi_s;
    logic [WIDTH-1:0]   res_lo_s;

    // A squashed instruction neither starts an op nor writes HI/LO
    assign accept_s = (state_r == IDLE) && start && !flush;
    assign mt_we_s  = (state_r == IDLE) && !start && !flush;
    assign commit_s = (state_r == FIX) && !flush;

    assign busy      = (state_r != IDLE);
    assign stall_req = busy && (start || hi_lo_access);
    assign hi        = hi_r;
    assign lo        = lo_r;
    assign done      = done_r;

    muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk       (clk),
        .reset     (reset),
        .load      (accept_s),
        .step      (state_r == CALC),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .res_hi    (res_hi_s),
        .res_lo    (res_lo_s)
    );

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = CALC;
                end else begin
                    next_state_s = IDLE;
                end
            end
            CALC: begin
                if (flush) begin
                    next_state_s = IDLE;
                end else if (count_r == CNT_W'(WIDTH - 1)) begin
                    next_state_s = FIX;
                end else begin
                    next_state_s = CALC;
                end
            end
            FIX:     next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State and iteration counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            count_r <= '0;
        end else begin
            state_r <= next_state_s;
            if (accept_s) begin
                count_r <= '0;
            end else if (state_r == CALC) begin
                count_r <= count_r + CNT_W'(1);
            end else begin
                count_r <= count_r;
            end
        end
    end

    // HI/LO: result commit has precedence; MTHI/MTLO only when idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= commit_s;
            if (commit_s) begin
                hi_r <= res_hi_s;
                lo_r <= res_lo_s;
            end else if (mt_we_s) begin
                if (hi_we) begin
                    hi_r <= wdata;
                end else begin
                    hi_r <= hi_r;
                end
                if (lo_we) begin
                    lo_r <= wdata;
                end else begin
                    lo_r <= lo_r;
                end
            end else begin
                hi_r <= hi_r;
                lo_r <= lo_r;
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit (WIDTH=32).
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] operand_a = 32'h0;
    logic [31:0] operand_b = 32'h0;
    logic        flush = 1'b0;
    logic        hi_lo_access = 1'b0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall_req;

    int pass_cnt = 0;
    int total_cnt = 0;

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
        .hi_lo_access(hi_lo_access), .hi_we(hi_we), .lo_we(lo_we),
        .wdata(wdata), .hi(hi), .lo(lo), .busy(busy), .done(done),
        .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, wait for done; returns cycles-to-done and busy-cycle count
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_cycles);
        op = o; operand_a = a; operand_b = b; start = 1'b1;
        tick();
        start = 1'b0;
        busy_cycles = busy ? 1 : 0;
        lat = 0;
        while (lat < 100) begin
            tick();
            lat++;
            if (busy) busy_cycles++;
            if (done) break;
        end
        if (lat >= 100) begin
            total_cnt++;
            $display("FAIL done_timeout: no done within %0d cycles (op=%0d)", lat, o);
        end
    endtask

    task automatic test_reset();
        total_cnt++; if (hi !== 32'h0) $display("FAIL reset_hi: got %h want 0", hi); else pass_cnt++;
        total_cnt++; if (lo !== 32'h0) $display("FAIL reset_lo: got %h want 0", lo); else pass_cnt++;
        total_cnt++; if ({busy, done, stall_req} !== 3'b000)
            $display("FAIL reset_flags: busy/done/stall got %b want 000", {busy, done, stall_req});
        else pass_cnt++;
    endtask

    task automatic test_multu();
        int lat, bc;
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
        total_cnt++; if (lat !== 33) $display("FAIL multu_latency: got %0d want 33", lat); else pass_cnt++;
        total_cnt++; if (bc !== 33) $display("FAIL multu_busy_cycles: got %0d want 33", bc); else pass_cnt++;
        total_cnt++; if (hi !== 32'hFFFFFFFE) $display("FAIL multu_hi: got %h want fffffffe", hi); else pass_cnt++;
        total_cnt++; if (lo !== 32'h00000001) $display("FAIL multu_lo: got %h want 00000001", lo); else pass_cnt++;
        tick();
        total_cnt++; if (done !== 1'b0) $display("FAIL done_one_cycle: got %b want 0", done); else pass_cnt++;
    endtask

    task automatic test_mult_div();
        int lat, bc;
        run_op(2'b00, 32'hFFFFFFFD, 32'h00000005, lat, bc);
        total_cnt++; if (hi !== 32'hFFFFFFFF) $display("FAIL mult_neg_hi: got %h want ffffffff", hi); else pass_cnt++;
        total_cnt++; if (lo !== 32'hFFFFFFF1) $display("FAIL mult_neg_lo: got %h want fffffff1", lo); else pass_cnt++;
        run_op(2'b10, 32'hFFFFFFF9, 32'h00000002, lat, bc);
        total_cnt++; if (lo !== 32'hFFFFFFFD) $display("FAIL div_neg_quot: got %h want fffffffd", lo); else pass_cnt++;
        total_cnt++; if (hi !== 32'hFFFFFFFF) $display("FAIL div_neg_rem: got %h want ffffffff", hi); else pass_cnt++;
        run_op(2'b11, 32'd100, 32'd7, lat, bc);
        total_cnt++; if ({hi, lo} !== {32'd2, 32'd14}) $display("FAIL divu_basic: got %h_%h want 00000002_0000000e", hi, lo); else pass_cnt++;
    endtask

    task automatic test_div_corner();
        int lat, bc;
        run_op(2'b11, 32'h00000064, 32'h0, lat, bc);
        total_cnt++; if (lo !== 32'hFFFFFFFF) $display("FAIL divu_by_zero_lo: got %h want ffffffff", lo); else pass_cnt++;
        total_cnt++; if (hi !== 32'h00000064) $display("FAIL divu_by_zero_hi: got %h want 00000064", hi); else pass_cnt++;
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, lat, bc);
        total_cnt++; if (lo !== 32'h80000000) $display("FAIL div_overflow_lo: got %h want 80000000", lo); else pass_cnt++;
        total_cnt++; if (hi !== 32'h0) $display("FAIL div_overflow_hi: got %h want 0", hi); else pass_cnt++;
    endtask

    task automatic test_flush();
        bit saw_done;
        hi_we = 1'b1; wdata = 32'h11; tick();
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22; tick();
        lo_we = 1'b0;
        total_cnt++; if ({hi, lo} !== {32'h11, 32'h22}) $display("FAIL mt_preload: got %h_%h want 00000011_00000022", hi, lo); else pass_cnt++;
        op = 2'b00; operand_a = 32'd9; operand_b = 32'd9; start = 1'b1; tick();
        start = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        flush = 1'b1; tick();
        flush = 1'b0;
        total_cnt++; if (busy !== 1'b0) $display("FAIL flush_busy: got %b want 0", busy); else pass_cnt++;
        for (int i = 0; i < 40; i++) begin
            if (done) saw_done = 1'b1;
            tick();
        end
        total_cnt++; if (saw_done !== 1'b0) $display("FAIL flush_done: got done pulse want none"); else pass_cnt++;
        total_cnt++; if ({hi, lo} !== {32'h11, 32'h22}) $display("FAIL flush_hilo: got %h_%h want 00000011_00000022", hi, lo); else pass_cnt++;
    endtask

    task automatic test_stall();
        int n;
        op = 2'b01; operand_a = 32'd6; operand_b = 32'd7; start = 1'b1; tick();
        start = 1'b0;
        tick();
        total_cnt++; if (stall_req !== 1'b0) $display("FAIL stall_idle_access: got %b want 0", stall_req); else pass_cnt++;
        hi_lo_access = 1'b1; hi_we = 1'b1; wdata = 32'hDEAD; #1;
        total_cnt++; if (stall_req !== 1'b1) $display("FAIL stall_busy_access: got %b want 1", stall_req); else pass_cnt++;
        tick();
        hi_lo_access = 1'b0; hi_we = 1'b0;
        n = 0;
        while (!done && n < 100) begin tick(); n++; end
        total_cnt++; if ({hi, lo} !== {32'd0, 32'd42}) $display("FAIL stall_result: got %h_%h want 00000000_0000002a", hi, lo); else pass_cnt++;
        tick();
        hi_lo_access = 1'b1; hi_we = 1'b1; wdata = 32'hABCD; #1;
        total_cnt++; if (stall_req !== 1'b0) $display("FAIL stall_not_busy: got %b want 0", stall_req); else pass_cnt++;
        tick();
        hi_lo_access = 1'b0; hi_we = 1'b0;
        total_cnt++; if (hi !== 32'hABCD) $display("FAIL mthi_write: got %h want 0000abcd", hi); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        op = 2'b01; operand_a = 32'd7; operand_b = 32'd9; start = 1'b1; tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        #2 reset = 1'b0;
        #1;
        total_cnt++; if ({hi, lo} !== 64'h0) $display("FAIL async_reset_hilo: got %h_%h want 0_0", hi, lo); else pass_cnt++;
        total_cnt++; if ({busy, done} !== 2'b00) $display("FAIL async_reset_flags: busy/done got %b want 00", {busy, done}); else pass_cnt++;
        tick();
        reset = 1'b1;
        tick();
        run_op(2'b01, 32'd3, 32'd4, lat, bc);
        total_cnt++; if ({hi, lo} !== {32'd0, 32'd12}) $display("FAIL post_reset_multu: got %h_%h want 00000000_0000000c", hi, lo); else pass_cnt++;
    endtask

    initial begin
        tick();
        tick();
        test_reset();
        reset = 1'b1;
        tick();
        test_multu();
        test_mult_div();
        test_div_corner();
        test_flush();
        test_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
